// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the bit-counter sizing helper.
package serial_subtractor_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    // Counter must reach WIDTH-1; a 1-bit counter is the floor so WIDTH=1 still has a legal vector.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor: computes a - b - borrow_in for one bit position.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    logic a_xor_b;

    assign a_xor_b    = a ^ b;
    assign diff       = a_xor_b ^ borrow_in;
    assign borrow_out = (~a & b) | (~a_xor_b & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b: operands are shifted out LSB first through one full subtractor,
// results are shifted into the top of the result register, one bit per RUN cycle.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             bout_q, bout_d;

    logic             fs_diff;
    logic             fs_bout;
    logic [WIDTH-1:0] res_shift;

    full_subtractor u_fs (
        .a          (a_q[0]),
        .b          (b_q[0]),
        .borrow_in  (bin_q),
        .diff       (fs_diff),
        .borrow_out (fs_bout)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit i sits at position i.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_shift = fs_diff;
        end else begin : g_res_many
            assign res_shift = {fs_diff, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bout_d  = bout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    bin_d   = 1'b0;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                bin_d = fs_bout;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    bout_d  = fs_bout;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bout_q  <= bout_d;
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign diff       = res_q;
    assign borrow_out = bout_q;

endmodule
